// File: rtl/cache_controller_update_queue_if.sv
// Bundle of the protocol-unit update handshake, the scheduler hazard query
// and the registered cc3 update strobes of the cache-controller update queue.
//
// Handshake: an update bundle transfers on a clk edge where pu_update_valid
// and pu_update_ready are both high. The producer holds its bundle stable
// while valid is high and ready is low; ready never depends on valid.
interface cache_controller_update_queue_if #(
  parameter int DEPTH        = 4,
  parameter int MSHR_IDX_W   = 3,
  parameter int MSHR_ENTRY_W = 64,
  parameter int LINE_W       = 512,
  parameter int SET_W        = 6,
  parameter int WAY_W        = 2,
  parameter int STATE_W      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // protocol-unit side
  logic                    pu_update_valid;
  logic                    pu_update_ready;
  logic                    pu_mshr_en;
  logic [MSHR_IDX_W-1:0]   pu_mshr_index;
  logic [MSHR_ENTRY_W-1:0] pu_mshr_entry;
  logic [LINE_W-1:0]       pu_mshr_data;
  logic                    pu_coh_en;
  logic [SET_W-1:0]        pu_coh_set;
  logic [WAY_W-1:0]        pu_coh_way;
  logic [STATE_W-1:0]      pu_coh_state;
  logic                    pu_lru_fill_en;

  // scheduler side
  logic                    issue_stall;
  logic [SET_W-1:0]        lookup_set;
  logic                    lookup_pending;

  // lookup-stage update strobes
  logic                    cc3_update_mshr_en;
  logic [MSHR_IDX_W-1:0]   cc3_update_mshr_index;
  logic [MSHR_ENTRY_W-1:0] cc3_update_mshr_entry_info;
  logic [LINE_W-1:0]       cc3_update_mshr_entry_data;
  logic                    cc3_update_coherence_state_en;
  logic [SET_W-1:0]        cc3_update_coherence_state_index;
  logic [WAY_W-1:0]        cc3_update_coherence_state_way;
  logic [STATE_W-1:0]      cc3_update_coherence_state_entry;
  logic                    cc3_update_lru_fill_en;

  logic [CNT_W-1:0]        queue_count;

  modport master (
    output pu_update_valid, pu_mshr_en, pu_mshr_index, pu_mshr_entry,
           pu_mshr_data, pu_coh_en, pu_coh_set, pu_coh_way, pu_coh_state,
           pu_lru_fill_en, issue_stall, lookup_set,
    input  pu_update_ready, lookup_pending, cc3_update_mshr_en,
           cc3_update_mshr_index, cc3_update_mshr_entry_info,
           cc3_update_mshr_entry_data, cc3_update_coherence_state_en,
           cc3_update_coherence_state_index, cc3_update_coherence_state_way,
           cc3_update_coherence_state_entry, cc3_update_lru_fill_en,
           queue_count
  );

  modport slave (
    input  pu_update_valid, pu_mshr_en, pu_mshr_index, pu_mshr_entry,
           pu_mshr_data, pu_coh_en, pu_coh_set, pu_coh_way, pu_coh_state,
           pu_lru_fill_en, issue_stall, lookup_set,
    output pu_update_ready, lookup_pending, cc3_update_mshr_en,
           cc3_update_mshr_index, cc3_update_mshr_entry_info,
           cc3_update_mshr_entry_data, cc3_update_coherence_state_en,
           cc3_update_coherence_state_index, cc3_update_coherence_state_way,
           cc3_update_coherence_state_entry, cc3_update_lru_fill_en,
           queue_count
  );
endinterface

// File: rtl/cache_controller_update_queue.sv
// Update queue between the protocol unit and the cache-controller lookup
// stage. Bundles are buffered in a small FIFO and drained one per cycle onto
// registered single-cycle strobes. A combinational hazard port reports
// whether a coherence write to a queried set is still queued or issuing.
module cache_controller_update_queue #(
  parameter int DEPTH        = 4,
  parameter int MSHR_IDX_W   = 3,
  parameter int MSHR_ENTRY_W = 64,
  parameter int LINE_W       = 512,
  parameter int SET_W        = 6,
  parameter int WAY_W        = 2,
  parameter int STATE_W      = 4
) (
  input  logic clk,
  input  logic reset_n,
  cache_controller_update_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                    mshr_en;
    logic [MSHR_IDX_W-1:0]   mshr_index;
    logic [MSHR_ENTRY_W-1:0] mshr_entry;
    logic [LINE_W-1:0]       mshr_data;
    logic                    coh_en;
    logic [SET_W-1:0]        coh_set;
    logic [WAY_W-1:0]        coh_way;
    logic [STATE_W-1:0]      coh_state;
    logic                    lru_fill_en;
  } entry_t;

  // FIFO storage and control
  entry_t            mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // output registers
  logic                    out_mshr_en_q;
  logic [MSHR_IDX_W-1:0]   out_mshr_index_q;
  logic [MSHR_ENTRY_W-1:0] out_mshr_entry_q;
  logic [LINE_W-1:0]       out_mshr_data_q;
  logic                    out_coh_en_q;
  logic [SET_W-1:0]        out_coh_set_q;
  logic [WAY_W-1:0]        out_coh_way_q;
  logic [STATE_W-1:0]      out_coh_state_q;
  logic                    out_lru_en_q;

  entry_t in_entry;
  entry_t head;
  logic   ready;
  logic   enq;
  logic   deq;
  logic   pending;

  // Ready comes from the registered count only, so a full queue never
  // accepts in the same cycle it drains.
  assign ready = (count_q < CNT_W'(DEPTH));
  // Bundles with no write enabled are acknowledged but never stored.
  assign enq   = bus.pu_update_valid & ready & (bus.pu_mshr_en | bus.pu_coh_en);
  assign deq   = (count_q != '0) & ~bus.issue_stall;
  assign head  = mem_q[rd_ptr_q];

  // Pack the incoming bundle; a pLRU fill only makes sense with a state write.
  always_comb begin
    in_entry             = '0;
    in_entry.mshr_en     = bus.pu_mshr_en;
    in_entry.mshr_index  = bus.pu_mshr_index;
    in_entry.mshr_entry  = bus.pu_mshr_entry;
    in_entry.mshr_data   = bus.pu_mshr_data;
    in_entry.coh_en      = bus.pu_coh_en;
    in_entry.coh_set     = bus.pu_coh_set;
    in_entry.coh_way     = bus.pu_coh_way;
    in_entry.coh_state   = bus.pu_coh_state;
    in_entry.lru_fill_en = bus.pu_lru_fill_en & bus.pu_coh_en;
  end

  // Next-state for pointers, per-slot valid bits and occupancy.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Payload storage; validity is tracked by valid_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Issue stage: strobes pulse for one cycle per dequeue, fields hold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_mshr_en_q    <= 1'b0;
      out_mshr_index_q <= '0;
      out_mshr_entry_q <= '0;
      out_mshr_data_q  <= '0;
      out_coh_en_q     <= 1'b0;
      out_coh_set_q    <= '0;
      out_coh_way_q    <= '0;
      out_coh_state_q  <= '0;
      out_lru_en_q     <= 1'b0;
    end else begin
      out_mshr_en_q <= deq & head.mshr_en;
      out_coh_en_q  <= deq & head.coh_en;
      out_lru_en_q  <= deq & head.lru_fill_en;
      if (deq) begin
        out_mshr_index_q <= head.mshr_index;
        out_mshr_entry_q <= head.mshr_entry;
        out_mshr_data_q  <= head.mshr_data;
        out_coh_set_q    <= head.coh_set;
        out_coh_way_q    <= head.coh_way;
        out_coh_state_q  <= head.coh_state;
      end
    end
  end

  // Set hazard: any stored coherence write or the one currently issuing.
  always_comb begin
    pending = out_coh_en_q && (out_coh_set_q == bus.lookup_set);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && mem_q[i].coh_en && (mem_q[i].coh_set == bus.lookup_set)) begin
        pending = 1'b1;
      end
    end
  end

  assign bus.pu_update_ready                  = ready;
  assign bus.lookup_pending                   = pending;
  assign bus.queue_count                      = count_q;
  assign bus.cc3_update_mshr_en               = out_mshr_en_q;
  assign bus.cc3_update_mshr_index            = out_mshr_index_q;
  assign bus.cc3_update_mshr_entry_info       = out_mshr_entry_q;
  assign bus.cc3_update_mshr_entry_data       = out_mshr_data_q;
  assign bus.cc3_update_coherence_state_en    = out_coh_en_q;
  assign bus.cc3_update_coherence_state_index = out_coh_set_q;
  assign bus.cc3_update_coherence_state_way   = out_coh_way_q;
  assign bus.cc3_update_coherence_state_entry = out_coh_state_q;
  assign bus.cc3_update_lru_fill_en           = out_lru_en_q;
endmodule

// File: tb/tb_cache_controller_update_queue.sv
// Directed bench for the cache-controller update queue: a per-cycle vector
// table plus hand-written reset and streaming sequences.
module tb_cache_controller_update_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cache_controller_update_queue_if #(
    .DEPTH(DEPTH), .MSHR_IDX_W(3), .MSHR_ENTRY_W(64), .LINE_W(512),
    .SET_W(6), .WAY_W(2), .STATE_W(4)
  ) bus ();

  cache_controller_update_queue #(
    .DEPTH(DEPTH), .MSHR_IDX_W(3), .MSHR_ENTRY_W(64), .LINE_W(512),
    .SET_W(6), .WAY_W(2), .STATE_W(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic       v, m, c, l, stall;
    logic [2:0] idx;
    logic [5:0] set, lset;
    logic [1:0] way;
    logic [3:0] st;
    logic       rdy, em, ec, el, pend;
    logic [2:0] cnt, eidx;
    logic [5:0] eset;
    logic [1:0] eway;
    logic [3:0] est;
  } vec_t;

  vec_t       tbl[$];
  logic [14:0] exp_q[$];

  function automatic logic [63:0] entry_of(input logic [2:0] idx);
    return 64'hC0DE_0000_0000_0000 | {61'h0, idx};
  endfunction

  function automatic logic [511:0] data_of(input logic [2:0] idx);
    logic [63:0] w;
    w = 64'hA5A5_0000_0000_0000 | {61'h0, idx};
    return {8{w}};
  endfunction

  function automatic vec_t mk(input int v, m, idx, c, set, way, st, l, stall, lset,
                              input int rdy, cnt, em, ec, el, pend, eidx, eset, eway, est);
    vec_t t;
    t.v = v[0]; t.m = m[0]; t.idx = idx[2:0]; t.c = c[0]; t.set = set[5:0];
    t.way = way[1:0]; t.st = st[3:0]; t.l = l[0]; t.stall = stall[0];
    t.lset = lset[5:0]; t.rdy = rdy[0]; t.cnt = cnt[2:0]; t.em = em[0];
    t.ec = ec[0]; t.el = el[0]; t.pend = pend[0]; t.eidx = eidx[2:0];
    t.eset = eset[5:0]; t.eway = eway[1:0]; t.est = est[3:0];
    return t;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int v, m, idx, c, set, way, st, l, stall, lset);
    bus.pu_update_valid = v[0];
    bus.pu_mshr_en      = m[0];
    bus.pu_mshr_index   = idx[2:0];
    bus.pu_mshr_entry   = entry_of(idx[2:0]);
    bus.pu_mshr_data    = data_of(idx[2:0]);
    bus.pu_coh_en       = c[0];
    bus.pu_coh_set      = set[5:0];
    bus.pu_coh_way      = way[1:0];
    bus.pu_coh_state    = st[3:0];
    bus.pu_lru_fill_en  = l[0];
    bus.issue_stall     = stall[0];
    bus.lookup_set      = lset[5:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cnt"},  512'(bus.queue_count), 512'(0));
    chk({tag, "_rdy"},  512'(bus.pu_update_ready), 512'(1));
    chk({tag, "_mstr"}, 512'(bus.cc3_update_mshr_en), 512'(0));
    chk({tag, "_cstr"}, 512'(bus.cc3_update_coherence_state_en), 512'(0));
    chk({tag, "_lstr"}, 512'(bus.cc3_update_lru_fill_en), 512'(0));
  endtask

  initial begin
    logic [2:0] r_idx;
    logic [5:0] r_set;
    logic [1:0] r_way;
    logic [3:0] r_st;
    logic [14:0] got;
    logic [2:0] last_idx;

    // ---------------- clock / reset ----------------
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk_idle("reset");
    chk("reset_pend", 512'(bus.lookup_pending), 512'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- vector table ----------------
    // single bundle: strobes two edges after enqueue
    tbl.push_back(mk(1,1,5,1,'h12,2,3,1,0,'h12, 1,1,0,0,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h12,    1,0,1,1,1,1, 5,'h12,2,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h12,    1,0,0,0,0,0, 0,0,0,0));
    // both enables off: accepted and dropped
    tbl.push_back(mk(1,0,0,0,'h12,0,0,1,0,'h12, 1,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h12,    1,0,0,0,0,0, 0,0,0,0));
    // lru request without coherence write is suppressed
    tbl.push_back(mk(1,1,2,0,'h07,0,0,1,0,'h07, 1,1,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h07,    1,0,1,0,0,0, 2,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h07,    1,0,0,0,0,0, 0,0,0,0));
    // set hazard while stalled, then through issue
    tbl.push_back(mk(1,0,0,1,'h12,1,5,0,1,'h30, 1,1,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,1,'h30,3,9,1,1,'h30, 1,2,0,0,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,'h31,    1,2,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,'h12,    1,2,0,0,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h30,    1,1,0,1,0,1, 0,'h12,1,5));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h30,    1,0,0,1,1,1, 0,'h30,3,9));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h30,    1,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h12,    1,0,0,0,0,0, 0,0,0,0));
    // fill to full under stall: six offers, four accepted
    for (int k = 0; k < 6; k++) begin
      tbl.push_back(mk(1,1,k,1,'h20+k,k,k,0,1,'h3F,
                       (k < 3) ? 1 : 0, (k < 3) ? k+1 : 4, 0,0,0,0, 0,0,0,0));
    end
    // release: offered bundle 6 is refused (no full-cycle bypass)
    tbl.push_back(mk(1,1,6,1,'h26,2,6,0,0,'h3F, 1,3,1,1,0,0, 0,'h20,0,0));
    for (int j = 1; j < 4; j++) begin
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h3F, 1,3-j,1,1,0,0, j,'h20+j,j,j));
    end
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h3F, 1,0,0,0,0,0, 0,0,0,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].m, tbl[i].idx, tbl[i].c, tbl[i].set, tbl[i].way,
            tbl[i].st, tbl[i].l, tbl[i].stall, tbl[i].lset);
      step();
      chk($sformatf("r%0d_rdy", i),  512'(bus.pu_update_ready), 512'(tbl[i].rdy));
      chk($sformatf("r%0d_cnt", i),  512'(bus.queue_count), 512'(tbl[i].cnt));
      chk($sformatf("r%0d_mstr", i), 512'(bus.cc3_update_mshr_en), 512'(tbl[i].em));
      chk($sformatf("r%0d_cstr", i), 512'(bus.cc3_update_coherence_state_en), 512'(tbl[i].ec));
      chk($sformatf("r%0d_lstr", i), 512'(bus.cc3_update_lru_fill_en), 512'(tbl[i].el));
      chk($sformatf("r%0d_pend", i), 512'(bus.lookup_pending), 512'(tbl[i].pend));
      if (tbl[i].em) begin
        chk($sformatf("r%0d_midx", i), 512'(bus.cc3_update_mshr_index), 512'(tbl[i].eidx));
        chk($sformatf("r%0d_ment", i), 512'(bus.cc3_update_mshr_entry_info), 512'(entry_of(tbl[i].eidx)));
        chk($sformatf("r%0d_mdat", i), bus.cc3_update_mshr_entry_data, data_of(tbl[i].eidx));
      end
      if (tbl[i].ec) begin
        chk($sformatf("r%0d_cset", i), 512'(bus.cc3_update_coherence_state_index), 512'(tbl[i].eset));
        chk($sformatf("r%0d_cway", i), 512'(bus.cc3_update_coherence_state_way), 512'(tbl[i].eway));
        chk($sformatf("r%0d_cst", i),  512'(bus.cc3_update_coherence_state_entry), 512'(tbl[i].est));
      end
    end

    // ---------------- reset mid-operation ----------------
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 1, k, 1, 5+k, k, k, 1, 1, 'h3F);
      step();
    end
    chk("mid_fill_cnt", 512'(bus.queue_count), 512'(3));
    @(negedge clk);
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    step();
    chk_idle("mid_rst");
    for (int s = 5; s < 8; s++) begin
      bus.lookup_set = 6'(s);
      #1;
      chk($sformatf("mid_rst_pend%0d", s), 512'(bus.lookup_pending), 512'(0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    step();
    chk_idle("mid_post");

    // ---------------- streaming at count 2 ----------------
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      r_idx = 3'($urandom_range(0, 7));
      r_set = 6'($urandom_range(0, 62));
      r_way = 2'($urandom_range(0, 3));
      r_st  = 4'($urandom_range(0, 15));
      drive(1, 1, r_idx, 1, r_set, r_way, r_st, 0, (k < 2) ? 1 : 0, 'h3F);
      exp_q.push_back({r_idx, r_set, r_way, r_st});
      step();
      if (k < 2) begin
        chk($sformatf("st_pre%0d_cnt", k), 512'(bus.queue_count), 512'(k + 1));
      end else begin
        chk($sformatf("st%0d_cnt", k), 512'(bus.queue_count), 512'(2));
        chk($sformatf("st%0d_mstr", k), 512'(bus.cc3_update_mshr_en), 512'(1));
        got = {bus.cc3_update_mshr_index, bus.cc3_update_coherence_state_index,
               bus.cc3_update_coherence_state_way, bus.cc3_update_coherence_state_entry};
        chk($sformatf("st%0d_data", k), 512'(got), 512'(exp_q.pop_front()));
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h3F);
      step();
      chk($sformatf("drain%0d_cnt", k), 512'(bus.queue_count), 512'(1 - k));
      chk($sformatf("drain%0d_mstr", k), 512'(bus.cc3_update_mshr_en), 512'(1));
      got = {bus.cc3_update_mshr_index, bus.cc3_update_coherence_state_index,
             bus.cc3_update_coherence_state_way, bus.cc3_update_coherence_state_entry};
      chk($sformatf("drain%0d_data", k), 512'(got), 512'(exp_q[0]));
      last_idx = exp_q[0][14:12];
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    step();
    chk_idle("drain_idle");
    chk("drain_hold_idx", 512'(bus.cc3_update_mshr_index), 512'(last_idx));
    chk("drain_empty_q", 512'(exp_q.size()), 512'(0));

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cache_controller_update_queue.md
Name: cache_controller_update_queue

Overview:
- Write-side producer for the cache-controller update interface: MSHR entry/data writes, coherence-state writes and pLRU fill updates.
- Accepts update bundles from the protocol unit through a valid/ready handshake and buffers them in a FIFO.
- Drains at most one bundle per cycle onto registered single-cycle update strobes consumed by the lookup stage.
- Exposes a combinational pending-set hazard port so the scheduler can hold requests whose set has an update in flight.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- MSHR_IDX_W, 3, MSHR index width.
- MSHR_ENTRY_W, 64, packed MSHR entry-info width.
- LINE_W, 512, cache line width.
- SET_W, 6, set index width.
- WAY_W, 2, way index width.
- STATE_W, 4, packed coherence state width.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- pu_update_valid  in  1  update bundle offered
- pu_update_ready  out  1  queue can accept
- pu_mshr_en  in  1  bundle carries an MSHR write
- pu_mshr_index  in  MSHR_IDX_W  MSHR slot
- pu_mshr_entry  in  MSHR_ENTRY_W  entry info
- pu_mshr_data  in  LINE_W  entry data
- pu_coh_en  in  1  bundle carries a coherence-state write
- pu_coh_set  in  SET_W  target set
- pu_coh_way  in  WAY_W  target way
- pu_coh_state  in  STATE_W  new state
- pu_lru_fill_en  in  1  request pLRU fill update on coh set/way
- issue_stall  in  1  hold the head entry this cycle
- lookup_set  in  SET_W  hazard query set
- lookup_pending  out  1  a queued or issuing coherence write targets lookup_set
- cc3_update_mshr_en  out  1  MSHR write strobe
- cc3_update_mshr_index  out  MSHR_IDX_W
- cc3_update_mshr_entry_info  out  MSHR_ENTRY_W
- cc3_update_mshr_entry_data  out  LINE_W
- cc3_update_coherence_state_en  out  1  state write strobe
- cc3_update_coherence_state_index  out  SET_W
- cc3_update_coherence_state_way  out  WAY_W
- cc3_update_coherence_state_entry  out  STATE_W
- cc3_update_lru_fill_en  out  1  pLRU fill strobe
- queue_count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset: when reset_n is low at a clk edge, empty the FIFO and clear every output register to 0. queue_count=0 and pu_update_ready=1 from the first cycle after reset.
- Reset mid-operation: reset discards queued and issuing entries. No strobe is asserted in the cycle after the reset edge.
- pu_update_ready = (queue_count < DEPTH), decoded from registered count only. There is no full-cycle bypass: when full, a simultaneous dequeue does not let an enqueue in that same cycle.
- Enqueue happens on valid&ready.
  - A bundle with mshr_en=0 and coh_en=0 is accepted and discarded: no count change, no strobe.
  - lru_fill_en is stored as lru_fill_en&coh_en.
- Dequeue happens when count>0 and issue_stall=0.
  - At that edge all cc3_update_* fields are registered from the head entry. The strobes (mshr_en, coherence_state_en, lru_fill_en) take the entry's flags.
  - Strobes are high for exactly one cycle per entry.
  - When no dequeue occurs, the strobes register to 0. Data fields hold their last value.
- Latency: a bundle enqueued into an empty queue at edge k drives strobes during the cycle after edge k+1. Sustained throughput is 1 bundle/cycle.
- Simultaneous enqueue and dequeue with 0<count<DEPTH leaves count unchanged. Pointers wrap modulo DEPTH.
- Order is strict FIFO. Two entries to the same MSHR slot or set/way issue in arrival order.
- lookup_pending is combinational. It is 1 if either of the following matches lookup_set:
  - any valid FIFO entry with coh_en=1 and coh_set==lookup_set;
  - the output register (cc3_update_coherence_state_en=1 and cc3_update_coherence_state_index==lookup_set).
- An entry being enqueued in the current cycle is not visible to lookup_pending until the next cycle.

Test Plan:
- Reset, then one bundle {mshr_en=1,index=5,coh_en=1,set=0x12,way=2,state=3,lru=1} at cycle 0 -> at cycle 2 all three strobes high for one cycle, fields match; queue_count 1 then 0.
- Back-to-back 6 bundles with DEPTH=4 and issue_stall=1 -> ready drops after 4 accepts, count=4. Release stall -> 4 strobes on consecutive cycles in order, ready returns the cycle after first dequeue.
- Bundle with coh_en=0 and lru_fill_en=1 -> cc3_update_lru_fill_en stays 0. Bundle with both enables 0 -> accepted, count stays 0, no strobes.
- Queue entries for sets 0x12 and 0x30 with stall=1: lookup_set=0x30 -> pending=1; lookup_set=0x31 -> 0. After both issue and strobe cycle passes -> pending=0.
- 3 entries queued, drive reset_n=0 one cycle -> next cycle count=0, all strobes 0, ready=1, pending=0 for any set.
- Continuous enqueue/dequeue for 20 cycles at count=2 with wrap -> output sequence equals input sequence, count constant.
